// File: rtl/mult_pipe_if.sv
// Handshake bundle for mult_pipe: operand beat on the in_* side, result beat on the out_* side.
interface mult_pipe_if #(
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic [INPUT_WIDTH-1:0]  in0;
   logic [INPUT_WIDTH-1:0]  in1;
   logic                    in_signed;
   logic                    out_valid;
   logic                    out_ready;
   logic [OUTPUT_WIDTH-1:0] out;

   modport master (
      output in_valid, in0, in1, in_signed, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, in0, in1, in_signed, out_ready,
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned multiplier with collapsing valid/ready backpressure.
// Optional feature macro: MULT_PIPE_SATURATE_EN (saturate instead of truncate when narrowing).
module mult_pipe #(
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 16,
   parameter int STAGES       = 2
) (
   input logic        clock,
   input logic        reset,
   mult_pipe_if.slave bus
);
   localparam int PW  = 2 * INPUT_WIDTH;
   localparam int WW  = (OUTPUT_WIDTH > PW) ? OUTPUT_WIDTH : PW;
   localparam int MID = (STAGES > 1) ? STAGES - 1 : 1;

   // Extend, truncate or saturate the full product to the result width.
   function automatic logic [OUTPUT_WIDTH-1:0] resize_product(input logic [PW-1:0] p,
                                                              input logic          sgn);
      logic [WW-1:0]           ext_v;
      logic [OUTPUT_WIDTH-1:0] res_v;
`ifdef MULT_PIPE_SATURATE_EN
      logic [PW-1:0]           hi_u_v;
      logic signed [PW-1:0]    hi_s_v;
`endif
      if (sgn) begin
         ext_v = WW'($signed(p));
      end else begin
         ext_v = WW'(p);
      end
      res_v = ext_v[OUTPUT_WIDTH-1:0];
`ifdef MULT_PIPE_SATURATE_EN
      // Bits above the result must be all zero (unsigned) or all copies of the result sign (signed).
      hi_u_v = p >> OUTPUT_WIDTH;
      hi_s_v = $signed(p) >>> (OUTPUT_WIDTH - 1);
      if (OUTPUT_WIDTH < PW) begin
         if (sgn) begin
            if ((hi_s_v != '0) && (hi_s_v != '1)) begin
               res_v = p[PW-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                               : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
            end else begin
               res_v = ext_v[OUTPUT_WIDTH-1:0];
            end
         end else begin
            if (hi_u_v != '0) begin
               res_v = '1;
            end else begin
               res_v = ext_v[OUTPUT_WIDTH-1:0];
            end
         end
      end else begin
         res_v = ext_v[OUTPUT_WIDTH-1:0];
      end
`endif
      return res_v;
   endfunction

   logic [PW-1:0]           a_ext_s;
   logic [PW-1:0]           b_ext_s;
   logic [PW-1:0]           prod_s;
   logic [STAGES-1:0]       valid_r;
   logic [STAGES-1:0]       load_s;
   logic [STAGES-1:0]       up_valid_s;
   logic [STAGES-1:0]       up_sign_s;
   logic [MID-1:0]          sign_r;
   logic [PW-1:0]           mid_r [MID];
   logic [PW-1:0]           src_s [STAGES];
   logic [OUTPUT_WIDTH-1:0] res_r;

   // Operand extension by mode; the low PW bits of the extended product are exact in both modes.
   always_comb begin
      if (bus.in_signed) begin
         a_ext_s = {{INPUT_WIDTH{bus.in0[INPUT_WIDTH-1]}}, bus.in0};
         b_ext_s = {{INPUT_WIDTH{bus.in1[INPUT_WIDTH-1]}}, bus.in1};
      end else begin
         a_ext_s = {{INPUT_WIDTH{1'b0}}, bus.in0};
         b_ext_s = {{INPUT_WIDTH{1'b0}}, bus.in1};
      end
      prod_s = a_ext_s * b_ext_s;
   end

   // A stage may load when it or any stage below it has room, or the consumer takes the result.
   always_comb begin
      logic room_v;
      room_v = bus.out_ready;
      load_s = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         room_v    = room_v | ~valid_r[k];
         load_s[k] = room_v;
      end
   end

   // Upstream view of each stage: the input port for stage 0, the previous stage otherwise.
   always_comb begin
      up_valid_s    = '0;
      up_sign_s     = '0;
      for (int k = 0; k < STAGES; k++) begin
         src_s[k] = '0;
      end
      up_valid_s[0] = bus.in_valid;
      up_sign_s[0]  = bus.in_signed;
      src_s[0]      = prod_s;
      for (int k = 1; k < STAGES; k++) begin
         up_valid_s[k] = valid_r[k-1];
         up_sign_s[k]  = sign_r[k-1];
         src_s[k]      = mid_r[k-1];
      end
   end

   // Stage valid bits: an empty upstream slot moving in clears the stage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_r <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load_s[k]) begin
               valid_r[k] <= up_valid_s[k];
            end
         end
      end
   end

   // Stage payloads only change when a real beat moves in, so idle cycles leave data untouched.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sign_r <= '0;
         for (int k = 0; k < MID; k++) begin
            mid_r[k] <= '0;
         end
         res_r  <= '0;
      end else begin
         for (int k = 0; k < STAGES - 1; k++) begin
            if (load_s[k] && up_valid_s[k]) begin
               mid_r[k]  <= src_s[k];
               sign_r[k] <= up_sign_s[k];
            end
         end
         if (load_s[STAGES-1] && up_valid_s[STAGES-1]) begin
            res_r <= resize_product(src_s[STAGES-1], up_sign_s[STAGES-1]);
         end
      end
   end

   assign bus.in_ready  = load_s[0];
   assign bus.out_valid = valid_r[STAGES-1];
   assign bus.out       = res_r;
endmodule

// File: tb/tb_mult_pipe.sv
// Directed, table-driven bench for mult_pipe: a 16-bit-result and an 8-bit-result instance.
module tb_mult_pipe;
   logic clock = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   mult_pipe_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16)) bus0 ();
   mult_pipe_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(8))  bus1 ();

   mult_pipe #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .STAGES(2)) dut0 (
      .clock(clock), .reset(reset), .bus(bus0));
   mult_pipe #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(8), .STAGES(2)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1));

   always #5 clock = ~clock;

   typedef struct {
      logic       sg;
      logic [7:0] a;
      logic [7:0] b;
      logic [15:0] exp_w;
      logic [7:0] exp_t;
      logic [7:0] exp_s;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] narrow_exp(input vec_t v);
`ifdef MULT_PIPE_SATURATE_EN
      return v.exp_s;
`else
      return v.exp_t;
`endif
   endfunction

   task automatic drive0(input logic vld, input logic sg, input logic [7:0] a, input logic [7:0] b);
      bus0.in_valid  = vld;
      bus0.in_signed = sg;
      bus0.in0       = a;
      bus0.in1       = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 8'hC8, 8'h03, 16'h0258, 8'h58, 8'hFF};
      vecs[1]  = '{1'b1, 8'hFF, 8'h80, 16'h0080, 8'h80, 8'h7F};
      vecs[2]  = '{1'b0, 8'hFF, 8'h80, 16'h7F80, 8'h80, 8'hFF};
      vecs[3]  = '{1'b0, 8'h14, 8'h14, 16'h0190, 8'h90, 8'hFF};
      vecs[4]  = '{1'b1, 8'h9C, 8'h64, 16'hD8F0, 8'hF0, 8'h80};
      vecs[5]  = '{1'b1, 8'h0A, 8'h0C, 16'h0078, 8'h78, 8'h78};
      vecs[6]  = '{1'b1, 8'hF6, 8'h0D, 16'hFF7E, 8'h7E, 8'h80};
      vecs[7]  = '{1'b0, 8'h0F, 8'h11, 16'h00FF, 8'hFF, 8'hFF};
      vecs[8]  = '{1'b0, 8'h10, 8'h10, 16'h0100, 8'h00, 8'hFF};
      vecs[9]  = '{1'b1, 8'hF8, 8'h10, 16'hFF80, 8'h80, 8'h80};
      vecs[10] = '{1'b1, 8'h0C, 8'h0B, 16'h0084, 8'h84, 8'h7F};
      vecs[11] = '{1'b1, 8'h7F, 8'h80, 16'hC080, 8'h80, 8'h80};
      vecs[12] = '{1'b0, 8'h00, 8'hAB, 16'h0000, 8'h00, 8'h00};
      vecs[13] = '{1'b1, 8'hF7, 8'hF2, 16'h007E, 8'h7E, 8'h7E};

      reset = 1'b1;
      drive0(1'b0, 1'b0, 8'h00, 8'h00);
      bus0.out_ready = 1'b1;
      bus1.in_valid  = 1'b0;
      bus1.in_signed = 1'b0;
      bus1.in0       = 8'h00;
      bus1.in1       = 8'h00;
      bus1.out_ready = 1'b1;

      #12;
      @(negedge clock);
      check("reset_out_valid0", {31'd0, bus0.out_valid}, 32'd0);
      check("reset_out0", {16'd0, bus0.out}, 32'd0);
      check("reset_out_valid1", {31'd0, bus1.out_valid}, 32'd0);
      reset = 1'b0;
      #1;
      check("reset_in_ready0", {31'd0, bus0.in_ready}, 32'd1);
      check("reset_in_ready1", {31'd0, bus1.in_ready}, 32'd1);
      @(negedge clock);

      // Single beats through both instances, checking exact two-cycle latency.
      for (int i = 0; i < 14; i++) begin
         drive0(1'b1, vecs[i].sg, vecs[i].a, vecs[i].b);
         bus1.in_valid  = 1'b1;
         bus1.in_signed = vecs[i].sg;
         bus1.in0       = vecs[i].a;
         bus1.in1       = vecs[i].b;
         #1;
         check("vec_in_ready0", {31'd0, bus0.in_ready}, 32'd1);
         check("vec_in_ready1", {31'd0, bus1.in_ready}, 32'd1);
         @(negedge clock);
         bus0.in_valid = 1'b0;
         bus1.in_valid = 1'b0;
         check("vec_early_valid0", {31'd0, bus0.out_valid}, 32'd0);
         check("vec_early_valid1", {31'd0, bus1.out_valid}, 32'd0);
         @(negedge clock);
         check("vec_out_valid0", {31'd0, bus0.out_valid}, 32'd1);
         check("vec_out_valid1", {31'd0, bus1.out_valid}, 32'd1);
         check("vec_out_wide", {16'd0, bus0.out}, {16'd0, vecs[i].exp_w});
         check("vec_out_narrow", {24'd0, bus1.out}, {24'd0, narrow_exp(vecs[i])});
      end
      @(negedge clock);
      check("vec_drained", {31'd0, bus0.out_valid}, 32'd0);

      // Ten back-to-back beats: consecutive, in-order results with in_ready never low.
      begin
         int rx = 0;
         int first = -1;
         int last = -1;
         for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 10) begin
               drive0(1'b1, 1'b0, 8'(cyc + 1), 8'(cyc + 2));
            end else begin
               bus0.in_valid = 1'b0;
            end
            #1;
            if (cyc < 10) begin
               check("stream_in_ready", {31'd0, bus0.in_ready}, 32'd1);
            end
            if (bus0.out_valid) begin
               check("stream_data", {16'd0, bus0.out}, 32'((rx + 1) * (rx + 2)));
               if (first < 0) begin
                  first = cyc;
               end
               last = cyc;
               rx++;
            end
            @(negedge clock);
         end
         check("stream_count", 32'(rx), 32'd10);
         check("stream_span", 32'(last - first), 32'd9);
      end

      // Backpressure: two beats fill the pipe, the third waits until out_ready rises.
      bus0.out_ready = 1'b0;
      drive0(1'b1, 1'b0, 8'd3, 8'd4);
      #1;
      check("bp_accept_a", {31'd0, bus0.in_ready}, 32'd1);
      @(negedge clock);
      drive0(1'b1, 1'b0, 8'd5, 8'd6);
      #1;
      check("bp_accept_b", {31'd0, bus0.in_ready}, 32'd1);
      @(negedge clock);
      drive0(1'b1, 1'b0, 8'd7, 8'd8);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp_full_in_ready", {31'd0, bus0.in_ready}, 32'd0);
         check("bp_hold_valid", {31'd0, bus0.out_valid}, 32'd1);
         check("bp_hold_out", {16'd0, bus0.out}, 32'd12);
         @(negedge clock);
      end
      bus0.out_ready = 1'b1;
      #1;
      check("bp_simul_accept", {31'd0, bus0.in_ready}, 32'd1);
      @(negedge clock);
      bus0.in_valid = 1'b0;
      #1;
      check("bp_out_b_valid", {31'd0, bus0.out_valid}, 32'd1);
      check("bp_out_b", {16'd0, bus0.out}, 32'd30);
      @(negedge clock);
      #1;
      check("bp_out_c_valid", {31'd0, bus0.out_valid}, 32'd1);
      check("bp_out_c", {16'd0, bus0.out}, 32'd56);
      @(negedge clock);
      #1;
      check("bp_empty", {31'd0, bus0.out_valid}, 32'd0);
      @(negedge clock);

      // Reset with two beats in flight clears outputs immediately; nothing stale follows.
      bus0.out_ready = 1'b0;
      drive0(1'b1, 1'b0, 8'd9, 8'd9);
      @(negedge clock);
      drive0(1'b1, 1'b0, 8'd2, 8'd2);
      @(negedge clock);
      bus0.in_valid = 1'b0;
      #1;
      check("rst_pre_valid", {31'd0, bus0.out_valid}, 32'd1);
      check("rst_pre_out", {16'd0, bus0.out}, 32'd81);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_valid", {31'd0, bus0.out_valid}, 32'd0);
      check("rst_async_out", {16'd0, bus0.out}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      bus0.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rst_no_stale", {31'd0, bus0.out_valid}, 32'd0);
         @(negedge clock);
      end
      drive0(1'b1, 1'b0, 8'd6, 8'd7);
      @(negedge clock);
      bus0.in_valid = 1'b0;
      #1;
      check("rst_new_early", {31'd0, bus0.out_valid}, 32'd0);
      @(negedge clock);
      #1;
      check("rst_new_valid", {31'd0, bus0.out_valid}, 32'd1);
      check("rst_new_out", {16'd0, bus0.out}, 32'd42);
      @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
